// File: rtl/i2c_regmap_sync_pkg.sv
// Shared address map, write-request payload and helpers for the I2C register map.
package i2c_regmap_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned GP_MAX   = 16;

  localparam logic [ADDR_W-1:0] ADDR_ID        = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 8'h02;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_FLAGS = 8'h03;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK  = 8'h04;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH   = 8'h05;
  localparam logic [ADDR_W-1:0] ADDR_WR_CNT    = 8'h06;
  localparam logic [ADDR_W-1:0] ADDR_GP_BASE   = 8'h10;

  localparam int unsigned CTRL_LOCK_BIT = 7;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Address of general-purpose register idx.
  function automatic logic [ADDR_W-1:0] gp_addr(input int unsigned idx);
    return ADDR_GP_BASE + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/i2c_regmap_sync_if.sv
// Regmap-side bus between the I2C slave core (master) and the register map (slave).
interface i2c_regmap_sync_if;
  import i2c_regmap_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr_en_wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output wdata, output wr_en_wdata, input rdata);
  modport slave  (input addr, input wdata, input wr_en_wdata, output rdata);
endinterface

// File: rtl/i2c_regmap_sync_pulse.sv
// i2c_pulse_sync: 2-flop synchronizer plus rising-edge detector giving a registered 1-clk pulse.
module i2c_pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  logic       s1_q, s2_q, s3_q;
  logic [1:0] vld_q;
  logic       armed_q, armed_d;
  logic       pulse_q, pulse_d;

  // Arm only after a genuine synchronized low, so a level already high at reset release is ignored.
  always_comb begin
    armed_d = armed_q | (vld_q[1] & ~s2_q);
    pulse_d = armed_q & s2_q & ~s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= async_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/i2c_regmap_sync.sv
// Register map fed by SCL-domain write events, synchronized into clk.
// Optional lock bit in CTRL[7] enabled by `define REGMAP_LOCK_EN.
module i2c_regmap_sync
  import i2c_regmap_pkg::*;
#(
  parameter logic [7:0]  ID_VALUE = 8'hA7,
  parameter logic [7:0]  CTRL_RST = 8'h00,
  parameter int unsigned NUM_GP   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  i2c_regmap_sync_if.slave         bus,
  input  logic [DATA_W-1:0]        status_in,
  input  logic [DATA_W-1:0]        irq_src,
  output logic [DATA_W-1:0]        ctrl,
  output logic [DATA_W*NUM_GP-1:0] gp_regs,
  output logic                     irq,
  output logic                     wr_strobe,
  output logic [ADDR_W-1:0]        wr_addr
);

`ifdef REGMAP_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              wr_pulse;
  wr_req_t           req_c;
  logic              locked_c;

  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] flags_q, flags_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] stat_s1_q, stat_s2_q;
  logic [DATA_W-1:0] gp_q [NUM_GP];
  logic [DATA_W-1:0] gp_d [NUM_GP];
  logic              irq_q, irq_d;
  logic              strobe_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  i2c_pulse_sync u_wr_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.wr_en_wdata),
    .pulse_o (wr_pulse)
  );

  // addr/wdata are quasi-static while the pulse is in flight, so they are sampled directly.
  assign req_c    = wr_req_t'{addr: bus.addr, data: bus.wdata};
  assign locked_c = LOCK_EN & ctrl_q[CTRL_LOCK_BIT];

  always_comb begin
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    gp_d      = gp_q;
    flags_d   = flags_q | irq_src;
    irq_d     = |(flags_q & mask_q);
    if (wr_pulse) begin
      cnt_d     = cnt_q + DATA_W'(1);
      wr_addr_d = req_c.addr;
      case (req_c.addr)
        ADDR_CTRL:      ctrl_d  = req_c.data;
        // Set wins over a same-cycle W1C.
        ADDR_IRQ_FLAGS: flags_d = (flags_q & ~req_c.data) | irq_src;
        ADDR_IRQ_MASK:  mask_d  = req_c.data;
        ADDR_SCRATCH:   if (!locked_c) scratch_d = req_c.data;
        default: ;
      endcase
      for (int unsigned i = 0; i < NUM_GP; i++) begin
        if (req_c.addr == gp_addr(i) && !locked_c) gp_d[i] = req_c.data;
      end
    end
  end

  // Read mux over the previous cycle's register state.
  always_comb begin
    rdata_d = '0;
    case (bus.addr)
      ADDR_ID:        rdata_d = ID_VALUE;
      ADDR_CTRL:      rdata_d = ctrl_q;
      ADDR_STATUS:    rdata_d = stat_s2_q;
      ADDR_IRQ_FLAGS: rdata_d = flags_q;
      ADDR_IRQ_MASK:  rdata_d = mask_q;
      ADDR_SCRATCH:   rdata_d = scratch_q;
      ADDR_WR_CNT:    rdata_d = cnt_q;
      default: ;
    endcase
    for (int unsigned i = 0; i < NUM_GP; i++) begin
      if (bus.addr == gp_addr(i)) rdata_d = gp_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_RST;
      flags_q   <= '0;
      mask_q    <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      stat_s1_q <= '0;
      stat_s2_q <= '0;
      irq_q     <= 1'b0;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      for (int unsigned i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      flags_q   <= flags_d;
      mask_q    <= mask_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      stat_s1_q <= status_in;
      stat_s2_q <= stat_s1_q;
      irq_q     <= irq_d;
      strobe_q  <= wr_pulse;
      wr_addr_q <= wr_addr_d;
      for (int unsigned i = 0; i < NUM_GP; i++) gp_q[i] <= gp_d[i];
    end
  end

  always_comb begin
    gp_regs = '0;
    for (int unsigned i = 0; i < NUM_GP; i++) gp_regs[i*DATA_W +: DATA_W] = gp_q[i];
  end

  assign bus.rdata = rdata_q;
  assign ctrl      = ctrl_q;
  assign irq       = irq_q;
  assign wr_strobe = strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_i2c_regmap_sync.sv
// Scoreboard bench for i2c_regmap_sync: write addresses queued at stimulus, popped on wr_strobe.
module tb_i2c_regmap_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  status_in, irq_src, ctrl, wr_addr;
  logic [31:0] gp_regs;
  logic        irq, wr_strobe;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [7:0] exp_q [$];

  i2c_regmap_sync_if bus ();

  i2c_regmap_sync #(.ID_VALUE(8'hA7), .CTRL_RST(8'h00), .NUM_GP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .status_in (status_in),
    .irq_src   (irq_src),
    .ctrl      (ctrl),
    .gp_regs   (gp_regs),
    .irq       (irq),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr)
  );

  always #5 clk = ~clk;

  // Each accepted write must match the oldest pending expected address.
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      logic [7:0] ea;
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: wr_addr=%h with no write pending", wr_addr);
      end else begin
        ea = exp_q.pop_front();
        if (wr_addr !== ea) begin
          errors++;
          $display("FAIL wr_addr: got %h expected %h", wr_addr, ea);
        end
      end
    end
  end

  // One SCL-style write; optional irq_src injection on posedge src_at; lat = posedges until wr_strobe.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hi_clks,
                          input int src_at, input logic [7:0] src_val, output int lat);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    exp_q.push_back(a);
    repeat (2) @(negedge clk);
    bus.wr_en_wdata = 1'b1;
    lat = 0;
    for (int n = 1; n <= 16; n++) begin
      if (n == src_at) irq_src = src_val;
      @(posedge clk); #1;
      if (n == src_at) irq_src = 8'h00;
      if (lat == 0 && wr_strobe) lat = n;
      if (n == hi_clks) bus.wr_en_wdata = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.addr = a;
    repeat (2) @(posedge clk);
    #1 d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    bus.addr = 8'h00; bus.wdata = 8'h00; bus.wr_en_wdata = 1'b0;
    status_in = 8'h3C; irq_src = 8'h00;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL rdata_in_reset: got %h expected 00", bus.rdata); end
    checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL ctrl_reset: got %h expected 00", ctrl); end
    checks++; if (irq !== 1'b0 || wr_strobe !== 1'b0) begin errors++; $display("FAIL irq_strobe_reset: got %b%b expected 00", irq, wr_strobe); end
    checks++; if (gp_regs !== 32'h0 || wr_addr !== 8'h00) begin errors++; $display("FAIL gp_wraddr_reset: got %h/%h expected 0/00", gp_regs, wr_addr); end
    @(negedge clk); rst_n = 1'b1;
    read_reg(8'h00, d);
    checks++; if (d !== 8'hA7) begin errors++; $display("FAIL id_read: got %h expected a7", d); end
    read_reg(8'h06, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL wr_cnt_reset: got %h expected 00", d); end
    read_reg(8'h02, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL status_read: got %h expected 3c", d); end
  endtask

  task automatic test_gp_write();
    logic [7:0] d;
    int lat, s0;
    s0 = strobe_cnt;
    do_write(8'h11, 8'h5C, 4, 0, 8'h00, lat);
    // Rise on a negedge: update at the 4th posedge, i.e. 3.5 clk latency.
    checks++; if (lat !== 4) begin errors++; $display("FAIL write_latency: got %0d expected 4", lat); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL one_strobe: got %0d expected 1", strobe_cnt - s0); end
    checks++; if (gp_regs !== 32'h0000_5C00) begin errors++; $display("FAIL gp1_write: got %h expected 00005c00", gp_regs); end
    read_reg(8'h06, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL wr_cnt_one: got %h expected 01", d); end
    read_reg(8'h11, d);
    checks++; if (d !== 8'h5C) begin errors++; $display("FAIL gp1_read: got %h expected 5c", d); end
    s0 = strobe_cnt;
    do_write(8'h13, 8'hE1, 12, 0, 8'h00, lat);
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL held_high_one_write: got %0d expected 1", strobe_cnt - s0); end
    checks++; if (gp_regs !== 32'hE100_5C00) begin errors++; $display("FAIL gp3_write: got %h expected e1005c00", gp_regs); end
    do_write(8'h14, 8'h77, 4, 0, 8'h00, lat);
    read_reg(8'h14, d);
    checks++; if (d !== 8'h00 || gp_regs !== 32'hE100_5C00) begin errors++; $display("FAIL gp_beyond_num: got %h/%h expected 00/e1005c00", d, gp_regs); end
    do_write(8'h01, 8'h5A, 4, 0, 8'h00, lat);
    checks++; if (ctrl !== 8'h5A) begin errors++; $display("FAIL ctrl_write: got %h expected 5a", ctrl); end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    int lat;
    do_write(8'h04, 8'h01, 4, 0, 8'h00, lat);
    @(negedge clk); irq_src = 8'h81;
    @(negedge clk); irq_src = 8'h00;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", irq); end
    read_reg(8'h03, d);
    checks++; if (d !== 8'h81) begin errors++; $display("FAIL flags_set: got %h expected 81", d); end
    do_write(8'h03, 8'h01, 4, 0, 8'h00, lat);
    read_reg(8'h03, d);
    checks++; if (d !== 8'h80 || irq !== 1'b0) begin errors++; $display("FAIL w1c: got %h irq=%b expected 80 irq=0", d, irq); end
    @(negedge clk); irq_src = 8'h01;
    @(negedge clk); irq_src = 8'h00;
    do_write(8'h03, 8'h81, 4, 4, 8'h01, lat);
    read_reg(8'h03, d);
    checks++; if (d !== 8'h01 || lat !== 4) begin errors++; $display("FAIL set_wins: got %h lat=%0d expected 01 lat=4", d, lat); end
    do_write(8'h03, 8'h01, 4, 0, 8'h00, lat);
    do_write(8'h04, 8'h00, 4, 0, 8'h00, lat);
    read_reg(8'h03, d);
    checks++; if (d !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL flags_clear: got %h irq=%b expected 00 irq=0", d, irq); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int lat, s0;
    s0 = strobe_cnt;
    @(negedge clk);
    bus.addr = 8'h12; bus.wdata = 8'hAA; bus.wr_en_wdata = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    checks++; if (strobe_cnt - s0 !== 0 || gp_regs !== 32'h0 || wr_addr !== 8'h00) begin
      errors++; $display("FAIL reset_mid_write: strobes=%0d gp=%h wr_addr=%h expected 0/0/00", strobe_cnt - s0, gp_regs, wr_addr);
    end
    @(negedge clk); bus.wr_en_wdata = 1'b0;
    repeat (4) @(negedge clk);
    read_reg(8'h06, d);
    checks++; if (d !== 8'h00 || ctrl !== 8'h00) begin errors++; $display("FAIL reset_mid_state: cnt=%h ctrl=%h expected 00/00", d, ctrl); end
    do_write(8'h12, 8'h66, 4, 0, 8'h00, lat);
    checks++; if (gp_regs !== 32'h0066_0000) begin errors++; $display("FAIL write_after_reset: got %h expected 00660000", gp_regs); end
  endtask

  task automatic test_lock();
    logic [7:0] d;
    int lat;
    do_write(8'h05, 8'h11, 4, 0, 8'h00, lat);
    do_write(8'h01, 8'h80, 4, 0, 8'h00, lat);
    do_write(8'h05, 8'h33, 4, 0, 8'h00, lat);
    do_write(8'h10, 8'h99, 4, 0, 8'h00, lat);
    read_reg(8'h05, d);
`ifdef REGMAP_LOCK_EN
    checks++; if (d !== 8'h11 || gp_regs !== 32'h0066_0000) begin errors++; $display("FAIL locked_write: scratch=%h gp=%h expected 11/00660000", d, gp_regs); end
`else
    checks++; if (d !== 8'h33 || gp_regs !== 32'h0066_0099) begin errors++; $display("FAIL ctrl7_plain: scratch=%h gp=%h expected 33/00660099", d, gp_regs); end
`endif
    read_reg(8'h06, d);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL cnt_while_locked: got %h expected 05", d); end
    do_write(8'h01, 8'h00, 4, 0, 8'h00, lat);
    do_write(8'h05, 8'h33, 4, 0, 8'h00, lat);
    read_reg(8'h05, d);
    checks++; if (d !== 8'h33 || ctrl !== 8'h00) begin errors++; $display("FAIL unlock_retry: scratch=%h ctrl=%h expected 33/00", d, ctrl); end
  endtask

  task automatic test_unmapped_wrap();
    logic [7:0] d;
    int lat;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    do_write(8'h7F, 8'hEE, 4, 0, 8'h00, lat);
    read_reg(8'h7F, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read: got %h expected 00", d); end
    for (int i = 0; i < 256; i++) begin
      do_write(((i % 2) != 0) ? 8'h05 : 8'h00, 8'(i), 4, 0, 8'h00, lat);
      if (i == 254) begin
        read_reg(8'h06, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL wr_cnt_wrap0: got %h expected 00", d); end
      end
    end
    read_reg(8'h06, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL wr_cnt_wrap1: got %h expected 01", d); end
    read_reg(8'h00, d);
    checks++; if (d !== 8'hA7) begin errors++; $display("FAIL id_readonly: got %h expected a7", d); end
    read_reg(8'h05, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL scratch_last: got %h expected ff", d); end
  endtask

  initial begin
    test_reset();
    test_gp_write();
    test_irq();
    test_reset_mid();
    test_lock();
    test_unmapped_wrap();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobe: got %0d writes unacknowledged expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
